// File: rtl/array_frame_buffer_pkg.sv
// Shared types and constants for the array frame buffer.
package array_frame_buffer_types;

  localparam int FB_WIDTH_DEFAULT = 32;
  localparam int FB_DEPTH_DEFAULT = 5;

  // FILL collects a frame from the producer, DRAIN replays it to the consumer.
  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } fb_state_t;

  typedef logic [FB_WIDTH_DEFAULT-1:0] word_t;
  typedef word_t word_array_t [FB_DEPTH_DEFAULT];

  // Index counter width; a single-entry frame still needs a 1-bit index.
  function automatic int fb_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/array_frame_buffer_if.sv
// Bundle of the producer/consumer handshake signals around the frame buffer.
//
// Handshake: a word moves on a port at a rising clk edge where that port's
// notify (ready/valid driven by the buffer) and sync (driven by the peer) are
// both 1. sync while notify is 0 is ignored; notify never depends on sync.
interface array_frame_buffer_if
  import array_frame_buffer_types::*;
#(
  parameter int WIDTH = FB_WIDTH_DEFAULT,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] b_in;
  logic             b_in_sync;
  logic             b_in_notify;
  logic             mode_rev;
  logic [WIDTH-1:0] b_out;
  logic             b_out_sync;
  logic             b_out_notify;
  logic [WIDTH-1:0] frame_sum;
  logic [CNT_W-1:0] frames_done;
  fb_state_t        state_dbg;

  // Environment side: producer and consumer.
  modport master (
    output b_in, b_in_sync, mode_rev, b_out_sync,
    input  b_in_notify, b_out, b_out_notify, frame_sum, frames_done, state_dbg
  );

  // Buffer side.
  modport slave (
    input  b_in, b_in_sync, mode_rev, b_out_sync,
    output b_in_notify, b_out, b_out_notify, frame_sum, frames_done, state_dbg
  );
endinterface

// File: rtl/array_frame_buffer.sv
// Frame buffer: collects DEPTH words, then replays them forward or reversed.
// Also reports the modular sum of the frame and a drained-frame counter.
module array_frame_buffer
  import array_frame_buffer_types::*;
#(
  parameter int WIDTH = FB_WIDTH_DEFAULT,
  parameter int DEPTH = FB_DEPTH_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] b_in,
  input  logic             b_in_sync,
  output logic             b_in_notify,
  input  logic             mode_rev,
  output logic [WIDTH-1:0] b_out,
  input  logic             b_out_sync,
  output logic             b_out_notify,
  output logic [WIDTH-1:0] frame_sum,
  output logic [CNT_W-1:0] frames_done,
  output fb_state_t        state_dbg
);

  localparam int IDX_W = fb_idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  fb_state_t        state_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] rd_cnt_q;
  logic [IDX_W-1:0] rd_idx;
  logic             rev_q;
  logic             in_notify_q;
  logic             out_notify_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [CNT_W-1:0] done_q;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_notify_q & b_in_sync;
  assign out_fire = out_notify_q & b_out_sync;

  // First word of a frame restarts the sum; later words accumulate modulo 2^WIDTH.
  always_comb begin
    sum_d = (wr_idx_q == '0) ? b_in : (sum_q + b_in);
  end

  // Read address: rev is latched per frame, so the order cannot change mid-drain.
  always_comb begin
    rd_idx = rev_q ? (LAST_IDX - rd_cnt_q) : rd_cnt_q;
  end

  assign b_out        = mem_q[rd_idx];
  assign b_in_notify  = in_notify_q;
  assign b_out_notify = out_notify_q;
  assign frame_sum    = sum_q;
  assign frames_done  = done_q;
  assign state_dbg    = state_q;

  // FILL/DRAIN state machine with registered handshake outputs and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      state_q      <= FILL;
      wr_idx_q     <= '0;
      rd_cnt_q     <= '0;
      rev_q        <= 1'b0;
      in_notify_q  <= 1'b1;
      out_notify_q <= 1'b0;
      sum_q        <= '0;
      done_q       <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_fire) begin
            mem_q[wr_idx_q] <= b_in;
            sum_q           <= sum_d;
            if (wr_idx_q == '0) begin
              rev_q <= mode_rev;
            end
            if (wr_idx_q == LAST_IDX) begin
              wr_idx_q     <= '0;
              state_q      <= DRAIN;
              in_notify_q  <= 1'b0;
              out_notify_q <= 1'b1;
            end else begin
              wr_idx_q <= wr_idx_q + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (rd_cnt_q == LAST_IDX) begin
              rd_cnt_q     <= '0;
              done_q       <= done_q + CNT_W'(1);
              state_q      <= FILL;
              in_notify_q  <= 1'b1;
              out_notify_q <= 1'b0;
            end else begin
              rd_cnt_q <= rd_cnt_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q      <= FILL;
          in_notify_q  <= 1'b1;
          out_notify_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
